spi_mem_arbiter: RTL

- Shares one single-lane SPI memory bus (CS, SCLK, MOSI, MISO) between two requesters: the instruction-fetch port (16-bit reads) and the data port (8-bit reads/writes).
- Performs round-robin arbitration, then runs the complete SPI transaction itself (command, 24-bit address, data).
- Sits between the CPU core and the top-level uio pins. It replaces a fetch-only SPI reader so that the data memory can live in external SPI RAM.

---
 rtl/spi_mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter between the fetch and data ports for one single-lane SPI memory.
// Runs the whole frame itself: command, 24-bit address, then the data bytes (SPI mode 0).
module spi_mem_arbiter #(
    parameter int         CLK_DIV = 1,
    parameter logic [7:0] IF_BASE = 8'h00,
    parameter logic [7:0] D_BASE  = 8'h01,
    parameter int         CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    output logic [7:0]  d_rdata,
    output logic        d_valid,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_SHIFT = 2'd1;
    localparam logic [1:0]  ST_GAP   = 2'd2;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    logic [1:0]  state_reg;
    logic        last_grant_reg;   // 1 = data port had the last grant
    logic        prev_grant_reg;   // value before the current grant, restored on abort
    logic        cur_data_reg;
    logic        cur_we_reg;
    logic [47:0] tx_reg;
    logic [15:0] rx_reg;
    logic [5:0]  bit_cnt_reg;
    logic [15:0] div_cnt_reg;
    logic [15:0] gap_cnt_reg;
    logic        sclk_reg;
    logic        cs_n_reg;
    logic        mosi_reg;
    logic        if_valid_reg;
    logic        d_valid_reg;
    logic [15:0] if_rdata_reg;
    logic [7:0]  d_rdata_reg;

    logic        grant_any;
    logic        grant_data;
    logic [47:0] frame_next;
    logic [5:0]  last_bit;

    // Frames are left-aligned in 48 bits; data frames simply stop after bit 39.
    always_comb begin
        grant_any  = ena && (if_req || d_req);
        grant_data = d_req && (!if_req || !last_grant_reg);
        if (grant_data) begin
            frame_next = {(d_we ? 8'h02 : 8'h03), D_BASE, d_addr, (d_we ? d_wdata : 8'h00), 8'h00};
        end else begin
            frame_next = {8'h03, IF_BASE, if_addr, 16'h0000};
        end
        last_bit = cur_data_reg ? 6'd39 : 6'd47;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            prev_grant_reg <= 1'b1;
            cur_data_reg   <= 1'b0;
            cur_we_reg     <= 1'b0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            bit_cnt_reg    <= '0;
            div_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            sclk_reg       <= 1'b0;
            cs_n_reg       <= 1'b1;
            mosi_reg       <= 1'b0;
            if_valid_reg   <= 1'b0;
            d_valid_reg    <= 1'b0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
        end else begin
            if_valid_reg <= 1'b0;
            d_valid_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        prev_grant_reg <= last_grant_reg;
                        last_grant_reg <= grant_data;
                        cur_data_reg   <= grant_data;
                        cur_we_reg     <= grant_data && d_we;
                        mosi_reg       <= frame_next[47];
                        tx_reg         <= {frame_next[46:0], 1'b0};
                        cs_n_reg       <= 1'b0;
                        sclk_reg       <= 1'b0;
                        bit_cnt_reg    <= '0;
                        div_cnt_reg    <= '0;
                        state_reg      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!ena) begin
                        cs_n_reg       <= 1'b1;
                        sclk_reg       <= 1'b0;
                        mosi_reg       <= 1'b0;
                        last_grant_reg <= prev_grant_reg;
                        gap_cnt_reg    <= '0;
                        state_reg      <= ST_GAP;
                    end else if (div_cnt_reg != DIV_LAST) begin
                        div_cnt_reg <= div_cnt_reg + 16'd1;
                    end else begin
                        div_cnt_reg <= '0;
                        if (!sclk_reg) begin
                            sclk_reg <= 1'b1;
                            rx_reg   <= {rx_reg[14:0], spi_miso};
                        end else if (bit_cnt_reg == last_bit) begin
                            sclk_reg    <= 1'b0;
                            cs_n_reg    <= 1'b1;
                            mosi_reg    <= 1'b0;
                            gap_cnt_reg <= '0;
                            state_reg   <= ST_GAP;
                            if (cur_data_reg) begin
                                d_valid_reg <= 1'b1;
                                if (!cur_we_reg) begin
                                    d_rdata_reg <= rx_reg[7:0];
                                end
                            end else begin
                                if_valid_reg <= 1'b1;
                                if_rdata_reg <= rx_reg;
                            end
                        end else begin
                            sclk_reg    <= 1'b0;
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            mosi_reg    <= tx_reg[47];
                            tx_reg      <= {tx_reg[46:0], 1'b0};
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign spi_cs_n = cs_n_reg;
    assign spi_sclk = sclk_reg;
    assign spi_mosi = mosi_reg;
    assign if_valid = if_valid_reg;
    assign d_valid  = d_valid_reg;
    assign if_rdata = if_rdata_reg;
    assign d_rdata  = d_rdata_reg;

endmodule
